counter_control_unit: RTL and testbench
=======================================

// Module: counter_control_unit
// PURPOSE
//  Upstream control stage for the 0-9999 up/down counter. Turns three raw push-buttons into
//  the counter's control levels mode / run_stop / clear, replacing direct slide-switch drive.
//  Per-button debounce plus rising-edge detect, then a run/stop/clear FSM and a mode toggle.
//  Outputs wire straight to the counter's sw[0]=mode, sw[1]=run_stop, sw[2]=clear.
// PARAMETERS
//  TICK_DIV    100_000  clk cycles per debounce sample tick (1 kHz at 100 MHz)
//  DB_SAMPLES  8        consecutive equal samples needed to change a debounced level
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-low reset
//  btn_run_stop in   1  raw button, asynchronous, bouncy; 1 = pressed
//  btn_clear    in   1  raw button, 1 = pressed
//  btn_mode     in   1  raw button, 1 = pressed
//  o_mode       out  1  0 = count up, 1 = count down
//  o_run_stop   out  1  1 = counter runs
//  o_clear      out  1  1-cycle clear request to counter
//  o_state      out  2  FSM state for debug/LED: 00 STOP, 01 RUN, 10 CLEAR
// BEHAVIOUR
//  Reset (reset==0 at posedge): o_mode=0, o_run_stop=0, o_clear=0, o_state=STOP, tick counter=0,
//   all sample shift regs and debounced levels =0, sync flops =0. Reset mid-debounce or mid-CLEAR
//   aborts it; no pulse issued after reset release.
//  Sync: each button passes 2 flops before sampling.
//  Tick: counter 0..TICK_DIV-1, tick=1 for one clk when it wraps to 0; shared by all buttons.
//  Debounce: on tick, shift synced bit into DB_SAMPLES-bit reg; level<=1 if all ones,
//   level<=0 if all zeros, else hold. Bounce shorter than DB_SAMPLES ticks never toggles level.
//  Edge: press pulse = level & ~level_d, exactly 1 clk, one per press; release gives no pulse.
//  FSM (state register, Moore outputs decoded from it, no extra latency):
//   STOP : rs pulse -> RUN; else clr pulse -> CLEAR; else stay.
//   RUN  : rs pulse -> STOP; clr pulse ignored (clear only while stopped).
//   CLEAR: unconditionally -> STOP next clk; pulses in this cycle are dropped.
//   o_run_stop = (state==RUN); o_clear = (state==CLEAR); illegal 11 -> STOP next clk.
//  Simultaneous rs+clr pulse in STOP: rs wins -> RUN, clear dropped.
//  Mode: mode pulse toggles o_mode in every state, independent of and same cycle as FSM moves.
//  Latency: debounced press edge -> pulse 1 clk -> output change 1 clk after pulse.
//   Press-to-output worst case = 2 sync + DB_SAMPLES*TICK_DIV + 2 clk.
//  Button held forever: single pulse only, no auto-repeat.
// STRUCTURE
//  Shared include counter_ctrl_defs.vh: state encodings ST_STOP=2'b00, ST_RUN=2'b01,
//   ST_CLEAR=2'b10 (also used by display/LED logic).
//  Sub-module btn_debounce (sync + shift reg + level + edge pulse), instantiated 3x;
//   takes tick as input. Tick counter and FSM live in counter_control_unit.
// TESTING (bench overrides TICK_DIV=4, DB_SAMPLES=4; 10 ns clk)
//  1 reset=0 for 2 clk, buttons 0 -> all outputs 0, o_state=00 during and after release.
//  2 btn_run_stop clean press held 30 clk -> exactly one o_run_stop 0->1, o_state=01;
//    second press -> 0, state 00.
//  3 btn_run_stop bounce 1/0 every 3 clk for 40 clk then released -> no output change,
//    no pulse.
//  4 STOP, press btn_clear -> o_clear=1 for exactly 1 clk, state 10 then 00;
//    same press in RUN -> o_clear stays 0.
//  5 btn_mode pressed 3 times -> o_mode 0->1->0->1, one toggle per press;
//    held 200 clk -> one toggle.
//  6 run_stop and clear pressed same clk in STOP -> state 01, o_clear never 1;
//    reset mid-press -> outputs 0, no pulse.

Source files
------------

// File: rtl/counter_control_unit_pkg.sv
// Shared definitions for the counter control unit: FSM state encodings,
// default timing parameters and the run/stop/clear transition function.
package counter_control_unit_pkg;

    // State encodings are also decoded by the display/LED logic.
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    localparam int TICK_DIV_DEF   = 100_000;
    localparam int DB_SAMPLES_DEF = 8;

    // Run/stop/clear transition rules. run_stop has priority over clear in
    // STOP; clear is only honoured while stopped; CLEAR lasts one cycle.
    // The unused 2'b11 code falls back to STOP.
    function automatic logic [1:0] next_state(input logic [1:0] cur,
                                              input logic       rs,
                                              input logic       clr);
        logic [1:0] nxt;
        nxt = ST_STOP;
        case (cur)
            ST_STOP: begin
                if (rs)       nxt = ST_RUN;
                else if (clr) nxt = ST_CLEAR;
                else          nxt = ST_STOP;
            end
            ST_RUN:   nxt = rs ? ST_STOP : ST_RUN;
            ST_CLEAR: nxt = ST_STOP;
            default:  nxt = ST_STOP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/counter_control_unit_debounce.sv
// Single push-button conditioner: two-flop synchronizer, tick-sampled
// shift-register debounce and a one-clock press pulse.
module btn_debounce
    import counter_control_unit_pkg::*;
#(
    parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic pulse
);

    logic                  sync1;
    logic                  sync2;
    logic [DB_SAMPLES-1:0] samples;
    logic [DB_SAMPLES-1:0] samples_nxt;
    logic                  level;
    logic                  level_d;

    // Window after this tick's sample is shifted in; the level decision is
    // made on the updated window so a change takes exactly DB_SAMPLES ticks.
    assign samples_nxt = {samples[DB_SAMPLES-2:0], sync2};

    // Synchronize, sample on tick, and move the level only on a unanimous window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            samples <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (tick) begin
                samples <= samples_nxt;
                if (&samples_nxt)
                    level <= 1'b1;
                else if (~|samples_nxt)
                    level <= 1'b0;
            end
        end
    end

    // Rising edge of the debounced level only; releases produce nothing.
    assign pulse = level & ~level_d;

endmodule

// File: rtl/counter_control_unit.sv
// Push-button front end for the 0-9999 up/down counter: shared debounce
// tick, three button conditioners, run/stop/clear FSM and mode toggle.
module counter_control_unit
    import counter_control_unit_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    output logic       o_mode,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic [1:0] o_state
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          rs_pulse;
    logic          clr_pulse;
    logic          mode_pulse;
    logic [1:0]    state;
    logic [1:0]    state_nxt;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    // Free-running sample-tick divider shared by all three buttons.
    always_ff @(posedge clk) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_run_stop (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .btn   (btn_run_stop),
        .pulse (rs_pulse)
    );

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .btn   (btn_clear),
        .pulse (clr_pulse)
    );

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .btn   (btn_mode),
        .pulse (mode_pulse)
    );

    // Next state from the shared transition rules.
    always_comb begin
        state_nxt = next_state(state, rs_pulse, clr_pulse);
    end

    // FSM state plus outputs registered from the next state, so they always
    // equal the decode of the current state without an extra cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_STOP;
            o_run_stop <= 1'b0;
            o_clear    <= 1'b0;
            o_mode     <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_run_stop <= (state_nxt == ST_RUN);
            o_clear    <= (state_nxt == ST_CLEAR);
            if (mode_pulse)
                o_mode <= ~o_mode;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_counter_control_unit.sv
// Bench for counter_control_unit: directed scenarios plus randomized button
// activity, compared every cycle against a behavioural model.
module tb_counter_control_unit;

    localparam int TD = 4;
    localparam int DB = 4;
    localparam int S_STOP  = 0;
    localparam int S_RUN   = 1;
    localparam int S_CLEAR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_run_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_mode = 1'b0;
    logic       o_mode;
    logic       o_run_stop;
    logic       o_clear;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    counter_control_unit #(.TICK_DIV(TD), .DB_SAMPLES(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_mode     (btn_mode),
        .o_mode       (o_mode),
        .o_run_stop   (o_run_stop),
        .o_clear      (o_clear),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a button is sampled 2 clocks late on every TD-th clock;
    // its level follows the last DB samples when they agree; a rising level is
    // one press, and presses drive the state rules and the mode toggle.
    int m_cnt;
    bit m_pipe1 [3];
    bit m_pipe2 [3];
    bit m_lvl   [3];
    bit m_lvl_d [3];
    bit hist    [3][$];
    int m_state;
    bit m_mode;

    always @(posedge clk) begin
        bit raw [3];
        bit press [3];
        bit tk;
        bit all1, all0;
        raw[0] = btn_run_stop;
        raw[1] = btn_clear;
        raw[2] = btn_mode;
        if (!reset) begin
            m_cnt   = 0;
            m_state = S_STOP;
            m_mode  = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_pipe1[b] = 1'b0;
                m_pipe2[b] = 1'b0;
                m_lvl[b]   = 1'b0;
                m_lvl_d[b] = 1'b0;
                hist[b].delete();
                for (int k = 0; k < DB; k++) hist[b].push_back(1'b0);
            end
        end else begin
            for (int b = 0; b < 3; b++) press[b] = m_lvl[b] && !m_lvl_d[b];
            case (m_state)
                S_STOP:  m_state = press[0] ? S_RUN : (press[1] ? S_CLEAR : S_STOP);
                S_RUN:   m_state = press[0] ? S_STOP : S_RUN;
                default: m_state = S_STOP;
            endcase
            if (press[2]) m_mode = !m_mode;
            tk = (m_cnt == TD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            for (int b = 0; b < 3; b++) begin
                m_lvl_d[b] = m_lvl[b];
                if (tk) begin
                    hist[b].push_back(m_pipe2[b]);
                    if (hist[b].size() > DB) void'(hist[b].pop_front());
                    all1 = 1'b1;
                    all0 = 1'b1;
                    foreach (hist[b][k]) begin
                        if (hist[b][k]) all0 = 1'b0;
                        else            all1 = 1'b0;
                    end
                    if (all1) m_lvl[b] = 1'b1;
                    else if (all0) m_lvl[b] = 1'b0;
                end
                m_pipe2[b] = m_pipe1[b];
                m_pipe1[b] = raw[b];
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mode", o_mode, m_mode);
            chk("run_stop", o_run_stop, (m_state == S_RUN));
            chk("clear", o_clear, (m_state == S_CLEAR));
            chk("state", o_state, m_state);
        end
    end

    int clr_seen;
    int clr_state_seen;
    int rs_changes;
    logic prev_rs;

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (o_clear === 1'b1) clr_seen++;
            if (o_state === 2'b10) clr_state_seen++;
            if (o_run_stop !== prev_rs) rs_changes++;
            prev_rs = o_run_stop;
        end
    endtask

    task automatic press_rs();
        btn_run_stop = 1'b1; cycles(30);
        btn_run_stop = 1'b0; cycles(25);
    endtask

    task automatic press_clr();
        btn_clear = 1'b1; cycles(30);
        btn_clear = 1'b0; cycles(25);
    endtask

    task automatic press_mode(input int hold);
        btn_mode = 1'b1; cycles(hold);
        btn_mode = 1'b0; cycles(25);
    endtask

    initial begin
        // 1: reset held for two clocks
        reset = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", o_state, 0);
        chk("rst_run", o_run_stop, 0);
        chk("rst_clear", o_clear, 0);
        chk("rst_mode", o_mode, 0);
        reset = 1'b1;
        prev_rs = o_run_stop;
        cycles(10);
        chk("post_rst_state", o_state, 0);

        // 2: clean run/stop presses
        rs_changes = 0;
        press_rs();
        chk("run_on", o_run_stop, 1);
        chk("run_state", o_state, 1);
        chk("run_one_change", rs_changes, 1);
        press_rs();
        chk("run_off", o_run_stop, 0);
        chk("stop_state", o_state, 0);

        // 3: bouncing run/stop never settles
        rs_changes = 0;
        for (int i = 0; i < 40; i++) begin
            btn_run_stop = ((i / 3) % 2 == 0);
            cycles(1);
        end
        btn_run_stop = 1'b0;
        cycles(25);
        chk("bounce_changes", rs_changes, 0);
        chk("bounce_state", o_state, 0);

        // 4: clear in STOP pulses once, in RUN it is ignored
        clr_seen = 0;
        clr_state_seen = 0;
        press_clr();
        chk("clr_pulse_cnt", clr_seen, 1);
        chk("clr_state_cnt", clr_state_seen, 1);
        chk("clr_back_stop", o_state, 0);
        press_rs();
        clr_seen = 0;
        press_clr();
        chk("clr_in_run", clr_seen, 0);
        chk("clr_in_run_state", o_state, 1);
        press_rs();

        // 5: mode toggles once per press, long hold toggles once
        press_mode(30);
        chk("mode_1", o_mode, 1);
        press_mode(30);
        chk("mode_2", o_mode, 0);
        press_mode(30);
        chk("mode_3", o_mode, 1);
        press_mode(200);
        chk("mode_hold", o_mode, 0);

        // 6: simultaneous run/stop and clear in STOP, then reset mid-press
        clr_seen = 0;
        btn_run_stop = 1'b1;
        btn_clear = 1'b1;
        cycles(30);
        btn_run_stop = 1'b0;
        btn_clear = 1'b0;
        cycles(25);
        chk("both_state", o_state, 1);
        chk("both_no_clear", clr_seen, 0);
        btn_mode = 1'b1;
        btn_run_stop = 1'b1;
        cycles(10);
        reset = 1'b0;
        cycles(2);
        btn_mode = 1'b0;
        btn_run_stop = 1'b0;
        reset = 1'b1;
        rs_changes = 0;
        clr_seen = 0;
        cycles(40);
        chk("midrst_run", o_run_stop, 0);
        chk("midrst_state", o_state, 0);
        chk("midrst_mode", o_mode, 0);
        chk("midrst_changes", rs_changes, 0);

        // Random button activity, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            btn_run_stop = v[0];
            btn_clear    = v[1];
            btn_mode     = v[2];
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                cycles($urandom_range(1, 3));
                reset = 1'b1;
            end
            cycles($urandom_range(1, 40));
        end
        btn_run_stop = 1'b0;
        btn_clear = 1'b0;
        btn_mode = 1'b0;
        cycles(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
